// File: rtl/fp32_to_int_seq.sv
// -----------------------------------------------------------------------------
// fp32_to_int_seq
//   Iterative converter from an IEEE-754 single-precision value to a signed
//   32-bit two's-complement integer. The float is unpacked back to fixed point
//   by shifting the 24-bit significand SHIFT_STEP bits per cycle. One
//   conversion is in flight at a time. Both sides use a valid/ready handshake.
//
//   FSM: IDLE -> SHIFT -> FIN -> DONE -> IDLE. SHIFT is skipped when no shift
//   is needed, and always for special operands.
//
// Parameters
//   SHIFT_STEP  bits shifted per SHIFT cycle (legal values 1, 2, 4, 8)
//
// Build option
//   ROUND_NEAREST_EN  when defined, FIN rounds to nearest-even. When
//                     undefined, FIN truncates toward zero and guard/sticky
//                     only feed the inexact flag.
//
// Ports
//   clk        clock, all logic on posedge
//   rst        synchronous, active-high reset
//   in_valid   in_num valid
//   in_ready   converter idle and able to accept
//   in_num     {sign, exp[7:0], frac[22:0]}
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts result
//   out_int    two's-complement result, stable while out_valid
//   out_flags  {invalid, overflow, inexact}, stable while out_valid
// -----------------------------------------------------------------------------
module fp32_to_int_seq #(
    parameter int SHIFT_STEP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_num,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_int,
    output logic [2:0]  out_flags
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [4:0] STEP5 = 5'(SHIFT_STEP);

`ifdef ROUND_NEAREST_EN
    // With rounding, u == -1 (values in [0.5,1)) can round up to 1.
    localparam logic signed [9:0] U_MIN = -10'sd1;
`else
    localparam logic signed [9:0] U_MIN = 10'sd0;
`endif

    state_e state_q, state_d;

    // Working registers
    logic        sign_q;
    logic [31:0] mag_q;        // significand being aligned, or the final value for specials
    logic [4:0]  cnt_q;        // remaining shift distance
    logic        left_q;       // shift direction: 1 = left (u >= 23)
    logic        guard_q;      // last bit shifted out on a right shift
    logic        sticky_q;     // OR of all bits shifted out before the guard bit
    logic        spec_q;       // result was fixed at accept time
    logic [2:0]  spec_flags_q;
    logic [31:0] out_int_q;
    logic [2:0]  out_flags_q;

    // Accept-time decode
    logic [7:0]        exp_s;
    logic [22:0]       frac_s;
    logic signed [9:0] u_s;
    logic signed [9:0] diff_s;
    logic              dec_spec_s;
    logic [31:0]       dec_int_s;
    logic [2:0]        dec_flags_s;
    logic [4:0]        dec_cnt_s;
    logic              dec_left_s;
    logic              accept_s;

    // Shift step
    logic [31:0] sh_mag_s;
    logic        sh_guard_s;
    logic        sh_sticky_s;
    logic [4:0]  step_s;
    logic [4:0]  sh_cnt_s;

    // Finish step
    logic        round_inc_s;
    logic [31:0] rnd_mag_s;
    logic [31:0] fin_int_s;
    logic [2:0]  fin_flags_s;

    assign accept_s = in_valid && in_ready;

    // Classify the incoming operand and work out the shift needed.
    always_comb begin
        exp_s       = in_num[30:23];
        frac_s      = in_num[22:0];
        u_s         = $signed({2'b00, exp_s}) - 10'sd127;
        diff_s      = 10'sd0;
        dec_spec_s  = 1'b0;
        dec_int_s   = 32'd0;
        dec_flags_s = 3'b000;
        dec_cnt_s   = 5'd0;
        dec_left_s  = 1'b0;
        if (exp_s == 8'hFF) begin
            dec_spec_s = 1'b1;
            if (frac_s != 23'd0) begin
                dec_int_s   = 32'h7FFF_FFFF;
                dec_flags_s = 3'b100;
            end else begin
                dec_int_s   = in_num[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
                dec_flags_s = 3'b010;
            end
        end else if (exp_s == 8'h00) begin
            // Zero and denormals flush to zero.
            dec_spec_s  = 1'b1;
            dec_flags_s = {2'b00, (frac_s != 23'd0)};
        end else if (u_s >= 10'sd31) begin
            dec_spec_s = 1'b1;
            if (in_num == 32'hCF00_0000) begin
                // -2^31 is the one magnitude >= 2^31 that is representable.
                dec_int_s   = 32'h8000_0000;
                dec_flags_s = 3'b000;
            end else begin
                dec_int_s   = in_num[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
                dec_flags_s = 3'b010;
            end
        end else if (u_s < U_MIN) begin
            dec_spec_s  = 1'b1;
            dec_flags_s = 3'b001;
        end else if (u_s >= 10'sd23) begin
            diff_s     = u_s - 10'sd23;
            dec_left_s = 1'b1;
            dec_cnt_s  = diff_s[4:0];
        end else begin
            diff_s    = 10'sd23 - u_s;
            dec_cnt_s = diff_s[4:0];
        end
    end

    // One SHIFT cycle: up to SHIFT_STEP single-bit shifts, tracking guard/sticky.
    always_comb begin
        sh_mag_s    = mag_q;
        sh_guard_s  = guard_q;
        sh_sticky_s = sticky_q;
        for (int i = 0; i < SHIFT_STEP; i++) begin
            if (5'(i) < cnt_q) begin
                if (left_q) begin
                    sh_mag_s = {sh_mag_s[30:0], 1'b0};
                end else begin
                    sh_sticky_s = sh_sticky_s | sh_guard_s;
                    sh_guard_s  = sh_mag_s[0];
                    sh_mag_s    = {1'b0, sh_mag_s[31:1]};
                end
            end else begin
                sh_mag_s = sh_mag_s;
            end
        end
        step_s   = (cnt_q > STEP5) ? STEP5 : cnt_q;
        sh_cnt_s = cnt_q - step_s;
    end

    // Round, apply sign and pick the flags for the registered result.
    always_comb begin
`ifdef ROUND_NEAREST_EN
        round_inc_s = guard_q & (sticky_q | mag_q[0]);
`else
        round_inc_s = 1'b0;
`endif
        rnd_mag_s = mag_q + {31'd0, round_inc_s};
        fin_int_s = sign_q ? (32'd0 - rnd_mag_s) : rnd_mag_s;
        if (spec_q) begin
            fin_flags_s = spec_flags_q;
        end else begin
            fin_flags_s = {2'b00, guard_q | sticky_q};
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = (dec_cnt_s == 5'd0) ? FIN : SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (sh_cnt_s == 5'd0) begin
                    state_d = FIN;
                end else begin
                    state_d = SHIFT;
                end
            end
            FIN: state_d = DONE;
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        in_ready  = (state_q == IDLE) && !rst;
        out_valid = (state_q == DONE);
    end

    // Datapath registers: load at accept, shift in SHIFT, capture result in FIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            sign_q       <= 1'b0;
            mag_q        <= 32'd0;
            cnt_q        <= 5'd0;
            left_q       <= 1'b0;
            guard_q      <= 1'b0;
            sticky_q     <= 1'b0;
            spec_q       <= 1'b0;
            spec_flags_q <= 3'b000;
            out_int_q    <= 32'd0;
            out_flags_q  <= 3'b000;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        // Specials carry their final value in mag_q with sign cleared.
                        sign_q       <= dec_spec_s ? 1'b0 : in_num[31];
                        mag_q        <= dec_spec_s ? dec_int_s : {8'd0, 1'b1, frac_s};
                        cnt_q        <= dec_cnt_s;
                        left_q       <= dec_left_s;
                        guard_q      <= 1'b0;
                        sticky_q     <= 1'b0;
                        spec_q       <= dec_spec_s;
                        spec_flags_q <= dec_flags_s;
                    end else begin
                        cnt_q <= cnt_q;
                    end
                end
                SHIFT: begin
                    mag_q    <= sh_mag_s;
                    guard_q  <= sh_guard_s;
                    sticky_q <= sh_sticky_s;
                    cnt_q    <= sh_cnt_s;
                end
                FIN: begin
                    out_int_q   <= fin_int_s;
                    out_flags_q <= fin_flags_s;
                end
                default: begin
                    out_int_q <= out_int_q;
                end
            endcase
        end
    end

    assign out_int   = out_int_q;
    assign out_flags = out_flags_q;

endmodule

// File: tb/tb_fp32_to_int_seq.sv
// -----------------------------------------------------------------------------
// tb_fp32_to_int_seq
//   Drives two converters (SHIFT_STEP 1 and 8) with identical operands and
//   compares results, flags and latency against a reference model that
//   evaluates the float value with plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_fp32_to_int_seq;

    localparam int STEP_A = 1;
    localparam int STEP_B = 8;

`ifdef ROUND_NEAREST_EN
    localparam int U_LO = -1;
`else
    localparam int U_LO = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_num;

    logic        in_ready_a, out_valid_a, in_ready_b, out_valid_b;
    logic [31:0] out_int_a, out_int_b;
    logic [2:0]  out_flags_a, out_flags_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp32_to_int_seq #(.SHIFT_STEP(STEP_A)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_num(in_num), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_int(out_int_a), .out_flags(out_flags_a)
    );

    fp32_to_int_seq #(.SHIFT_STEP(STEP_B)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_num(in_num), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_int(out_int_b), .out_flags(out_flags_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Value-level model: value = mant * 2^(u-23); scaled by 2^24 to keep the
    // fraction as an integer remainder.
    function automatic void ref_model(input logic [31:0] x, output logic [31:0] r,
                                      output logic [2:0] f, output int cnt);
        int     e, u;
        longint mant, num, ip, rem;
        e    = int'(x[30:23]);
        u    = e - 127;
        mant = longint'(x[22:0]) + 64'sd8388608;
        r    = 32'd0;
        f    = 3'b000;
        cnt  = 0;
        if (e == 255) begin
            if (x[22:0] != 23'd0) begin
                r = 32'h7FFF_FFFF; f = 3'b100;
            end else begin
                r = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF; f = 3'b010;
            end
        end else if (e == 0) begin
            f = {2'b00, (x[22:0] != 23'd0)};
        end else if (u >= 31) begin
            if (x == 32'hCF00_0000) r = 32'h8000_0000;
            else begin
                r = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF; f = 3'b010;
            end
        end else if (u < U_LO) begin
            f = 3'b001;
        end else begin
            num = mant << (u + 1);
            ip  = num / 64'sd16777216;
            rem = num % 64'sd16777216;
`ifdef ROUND_NEAREST_EN
            if (rem > 64'sd8388608 || (rem == 64'sd8388608 && ip[0])) ip = ip + 1;
`endif
            f   = (rem != 0) ? 3'b001 : 3'b000;
            r   = x[31] ? 32'(-ip) : 32'(ip);
            cnt = (u >= 23) ? (u - 23) : (23 - u);
        end
    endfunction

    // Called at a negedge with both converters idle; returns at a negedge.
    task automatic convert(input string tag, input logic [31:0] num, input logic [31:0] exp_int,
                           input logic [2:0] exp_flags, input int exp_cnt, input int stall);
        int   lat_a, lat_b, exp_lat_a, exp_lat_b;
        logic stable;
        lat_a     = -1;
        lat_b     = -1;
        exp_lat_a = (exp_cnt == 0) ? 2 : 2 + (exp_cnt + STEP_A - 1) / STEP_A;
        exp_lat_b = (exp_cnt == 0) ? 2 : 2 + (exp_cnt + STEP_B - 1) / STEP_B;
        check({tag, " in_ready"}, {31'd0, in_ready_a & in_ready_b}, 32'd1);
        in_num    = num;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        for (int k = 1; k <= 40 && (lat_a < 0 || lat_b < 0); k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid_a && lat_a < 0) lat_a = k;
            if (out_valid_b && lat_b < 0) lat_b = k;
        end
        check({tag, " lat_a"}, lat_a, exp_lat_a);
        check({tag, " lat_b"}, lat_b, exp_lat_b);
        check({tag, " int_a"}, out_int_a, exp_int);
        check({tag, " int_b"}, out_int_b, exp_int);
        check({tag, " flags_a"}, {29'd0, out_flags_a}, {29'd0, exp_flags});
        check({tag, " flags_b"}, {29'd0, out_flags_b}, {29'd0, exp_flags});
        if (stall > 0) begin
            stable = 1'b1;
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                if (!(out_valid_a && out_int_a === exp_int && out_flags_a === exp_flags && !in_ready_a))
                    stable = 1'b0;
            end
            check({tag, " stall_hold"}, {31'd0, stable}, 32'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " release"}, {30'd0, out_valid_a | out_valid_b, in_ready_a & in_ready_b}, 32'd1);
    endtask

    initial begin
        logic [31:0] x, r;
        logic [2:0]  f;
        int          c;
        logic        quiet;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_num    = 32'd0;
        repeat (3) @(negedge clk);
        check("reset out_valid", {30'd0, out_valid_a, out_valid_b}, 32'd0);
        check("reset out_int", out_int_a | out_int_b, 32'd0);
        check("reset flags", {26'd0, out_flags_a, out_flags_b}, 32'd0);
        check("reset in_ready", {30'd0, in_ready_a, in_ready_b}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        convert("one", 32'h3F80_0000, 32'd1, 3'b000, 23, 5);
        convert("m123_456", 32'hC2F6_E979, 32'hFFFF_FF85, 3'b001, 17, 0);
        convert("two_p_five", 32'h4020_0000, 32'd2, 3'b001, 22, 0);
`ifdef ROUND_NEAREST_EN
        convert("one_p_five", 32'h3FC0_0000, 32'd2, 3'b001, 23, 0);
        convert("zero_p_75", 32'h3F40_0000, 32'd1, 3'b001, 24, 0);
        convert("zero_p_5", 32'h3F00_0000, 32'd0, 3'b001, 24, 0);
`else
        convert("one_p_five", 32'h3FC0_0000, 32'd1, 3'b001, 23, 0);
        convert("zero_p_75", 32'h3F40_0000, 32'd0, 3'b001, 0, 0);
        convert("zero_p_5", 32'h3F00_0000, 32'd0, 3'b001, 0, 0);
`endif
        convert("two_pow_31", 32'h4F00_0000, 32'h7FFF_FFFF, 3'b010, 0, 0);
        convert("neg_two_pow_31", 32'hCF00_0000, 32'h8000_0000, 3'b000, 0, 0);
        convert("nan", 32'h7FC0_0000, 32'h7FFF_FFFF, 3'b100, 0, 0);
        convert("neg_inf", 32'hFF80_0000, 32'h8000_0000, 3'b010, 0, 0);
        convert("denormal", 32'h0000_0001, 32'd0, 3'b001, 0, 0);
        convert("neg_zero", 32'h8000_0000, 32'd0, 3'b000, 0, 0);
        convert("max_finite", 32'h4EFF_FFFF, 32'h7FFF_FF80, 3'b000, 7, 0);

        for (int n = 0; n < 40; n++) begin
            x = $urandom;
            if (n % 2 == 0) x[30:23] = 8'(100 + $urandom_range(0, 60));
            ref_model(x, r, f, c);
            convert("random", x, r, f, c, 0);
        end

        // Reset in the middle of a conversion drops it.
        in_num   = 32'h3F80_0000;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst in_ready_low", {30'd0, in_ready_a, in_ready_b}, 32'd0);
        rst   = 1'b0;
        quiet = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (out_valid_a || out_valid_b) quiet = 1'b0;
        end
        check("midrst no_out_valid", {31'd0, quiet}, 32'd1);
        check("midrst in_ready", {30'd0, in_ready_a, in_ready_b}, 32'd3);
        check("midrst out_int", out_int_a | out_int_b, 32'd0);

        convert("after_rst", 32'hC040_0000, 32'hFFFF_FFFD, 3'b000, 22, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
